// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - data memory arbiter: core priority, bounded-wait grant for an external master
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {S_CPU, S_FORCE} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, next_state;
  logic [3:0] wait_cnt, next_wait;
  logic       cpu_req;
  logic       ext_sel;

  assign cpu_req = cpu_mem_read | cpu_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CPU;
      wait_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
    end
  end

  always_comb begin
    next_state = state;
    next_wait  = wait_cnt;
    ext_sel    = 1'b0;
    case (state)
      S_CPU: begin
        if (!ext_req) begin
          next_wait = 4'd0;
        end else if (!cpu_req) begin
          ext_sel   = 1'b1;
          next_wait = 4'd0;
        end else begin
          // core wins; count the loss and force the next cycle once the budget is spent
          next_wait = wait_cnt + 4'd1;
          if (next_wait == MAX_WAIT_C)
            next_state = S_FORCE;
        end
      end
      S_FORCE: begin
        ext_sel    = ext_req;
        next_state = S_CPU;
        next_wait  = 4'd0;
      end
      default: begin
        next_state = S_CPU;
        next_wait  = 4'd0;
      end
    endcase
  end

  assign ext_gnt   = ext_sel;
  assign cpu_stall = ext_sel & cpu_req;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    if (ext_sel) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_write = ext_we;
      mem_read  = ~ext_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_mem_write;
      mem_read  = cpu_mem_read;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= ext_sel & ~ext_we;
      if (ext_sel && !ext_we)
        ext_rdata <= mem_rdata;
    end
  end

endmodule
